// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath: controller state encoding and
// the counting limits used by the seconds, minutes and hours stages.
package clock_pkg;

    // Controller modes: frozen, free-running, and manual time setting.
    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        SET  = 2'd2
    } clk_state_t;

    // Minute and second modulus.
    localparam int C_MIN_MAX      = 60;
    // Default hour modulus (24-hour display).
    localparam int C_HOUR_MAX_DEF = 24;

endpackage

// File: rtl/mod_counter.sv
// Modulus-N wrap counter with synchronous clear.
// The wrap output is combinational: it is high in the cycle whose
// increment takes the count from N-1 back to 0, so it can serve as the carry
// into a following stage.
module mod_counter #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = inc && (cnt == LAST);

    // Count register: clear has priority, then increment with wrap at N-1.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // pre-edge values, independent of block evaluation order.
        if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/min_hour_gen.sv
// Minutes/hours stage of the clock. Detects the end of each minute from the
// falling edge of the upstream sec_tic level, runs a STOP/RUN/SET controller
// and drives two modulus counters (minutes, hours).
module min_hour_gen
    import clock_pkg::*;
#(
    parameter int P_MIN_BIT  = 6,
    parameter int P_HOUR_BIT = 5,
    parameter int P_HOUR_MAX = C_HOUR_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset_all,
    input  logic                  en,
    input  logic                  sec_tic,
    input  logic                  set_mode,
    input  logic                  inc_min,
    input  logic                  inc_hour,
    output logic [P_MIN_BIT-1:0]  min,
    output logic [P_HOUR_BIT-1:0] hour,
    output logic                  min_tic,
    output logic                  day_tic
);

    clk_state_t state;
    logic       sec_tic_d;
    logic       en_d;
    logic       minute_event;
    logic       min_inc;
    logic       hour_inc;
    logic       min_wrap;
    logic       hour_wrap;

    // A minute ends when sec_tic falls while en is high now and was high a
    // cycle ago. Requiring en_d rejects the drop of sec_tic that the upstream
    // stage produces when it is cleared by en falling.
    assign minute_event = sec_tic_d && !sec_tic && en && en_d;

    // Counter increments are chosen by the registered state. Kept as two
    // separate assigns so the hour carry path (min_inc -> min_wrap ->
    // hour_inc) is not seen as a combinational loop through one block.
    assign min_inc  = (state == RUN) ? minute_event :
                      (state == SET) ? inc_min      : 1'b0;
    assign hour_inc = (state == RUN) ? min_wrap     :
                      (state == SET) ? inc_hour     : 1'b0;

    assign min_tic = (min == P_MIN_BIT'(C_MIN_MAX - 1));

    // Controller: edge-detect registers, mode selection and the registered
    // end-of-day pulse, all cleared by reset_all.
    always_ff @(posedge clk) begin
        if (reset_all) begin
            state     <= STOP;
            sec_tic_d <= 1'b0;
            en_d      <= 1'b0;
            day_tic   <= 1'b0;
        end else begin
            sec_tic_d <= sec_tic;
            en_d      <= en;
            if (!en) begin
                state <= STOP;
            end else if (set_mode) begin
                state <= SET;
            end else begin
                state <= RUN;
            end
            // Only a natural rollover counts as a new day; setting the time
            // past midnight by hand does not.
            day_tic <= (state == RUN) && hour_wrap;
        end
    end

    mod_counter #(
        .N (C_MIN_MAX),
        .W (P_MIN_BIT)
    ) u_min_cnt (
        .clk  (clk),
        .clr  (reset_all),
        .inc  (min_inc),
        .cnt  (min),
        .wrap (min_wrap)
    );

    mod_counter #(
        .N (P_HOUR_MAX),
        .W (P_HOUR_BIT)
    ) u_hour_cnt (
        .clk  (clk),
        .clr  (reset_all),
        .inc  (hour_inc),
        .cnt  (hour),
        .wrap (hour_wrap)
    );

endmodule

// File: tb/tb_min_hour_gen.sv
// Self-checking bench for min_hour_gen: a table of per-cycle vectors plus
// hand-written sequences for rollover, enable drop, set mode and reset
// corners. A second instance with a 12-hour modulus covers the hour wrap.
module tb_min_hour_gen;
    import clock_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (24-hour).
    logic       reset_all, en, sec_tic, set_mode, inc_min, inc_hour;
    logic [5:0] min;
    logic [4:0] hour;
    logic       min_tic, day_tic;

    // Second instance (12-hour).
    logic       reset_b, en_b, set_mode_b, inc_hour_b;
    logic [5:0] min_b;
    logic [4:0] hour_b;
    logic       min_tic_b, day_tic_b;

    int n_checks = 0;
    int n_pass   = 0;

    min_hour_gen dut (
        .clk       (clk),
        .reset_all (reset_all),
        .en        (en),
        .sec_tic   (sec_tic),
        .set_mode  (set_mode),
        .inc_min   (inc_min),
        .inc_hour  (inc_hour),
        .min       (min),
        .hour      (hour),
        .min_tic   (min_tic),
        .day_tic   (day_tic)
    );

    min_hour_gen #(
        .P_MIN_BIT  (6),
        .P_HOUR_BIT (5),
        .P_HOUR_MAX (12)
    ) dut12 (
        .clk       (clk),
        .reset_all (reset_b),
        .en        (en_b),
        .sec_tic   (1'b0),
        .set_mode  (set_mode_b),
        .inc_min   (1'b0),
        .inc_hour  (inc_hour_b),
        .min       (min_b),
        .hour      (hour_b),
        .min_tic   (min_tic_b),
        .day_tic   (day_tic_b)
    );

    typedef struct {
        logic r, e, s, sm, im, ih;
        int   eh, em;
        logic ed;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic r, logic e, logic s, logic sm, logic im,
                                logic ih, int eh, int em, logic ed);
        vec_t v;
        v.r = r; v.e = e; v.s = s; v.sm = sm; v.im = im; v.ih = ih;
        v.eh = eh; v.em = em; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive one cycle of inputs, clock it, and settle just after the edge.
    task automatic cyc(input logic r, input logic e, input logic s,
                       input logic sm, input logic im, input logic ih);
        reset_all = r; en = e; sec_tic = s;
        set_mode = sm; inc_min = im; inc_hour = ih;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_time(input string name, input int h, input int m,
                               input int d);
        check({name, "_hour"}, int'(hour), h);
        check({name, "_min"}, int'(min), m);
        check({name, "_day"}, int'(day_tic), d);
    endtask

    // Reset, enter SET, then pulse inc_hour/inc_min the required times.
    task automatic set_time(input int h, input int m);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < h; i++) begin
            cyc(0, 1, 0, 1, 0, 1);
            cyc(0, 1, 0, 1, 0, 0);
        end
        for (int i = 0; i < m; i++) begin
            cyc(0, 1, 0, 1, 1, 0);
            cyc(0, 1, 0, 1, 0, 0);
        end
    endtask

    initial begin
        reset_all = 1'b0; en = 1'b0; sec_tic = 1'b0;
        set_mode = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        reset_b = 1'b1; en_b = 1'b0; set_mode_b = 1'b0; inc_hour_b = 1'b0;

        // r  e  s  sm im ih   hh mm day   (expected after the edge)
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);  // fall seen -> min=1
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[8]  = mk(0, 1, 0, 1, 1, 0, 0, 1, 0);  // still RUN: inc ignored
        vecs[9]  = mk(0, 1, 0, 1, 1, 0, 0, 2, 0);  // SET: inc_min
        vecs[10] = mk(0, 1, 0, 1, 0, 1, 1, 2, 0);  // SET: inc_hour
        vecs[11] = mk(0, 1, 0, 1, 1, 1, 2, 3, 0);  // SET: both
        vecs[12] = mk(0, 1, 1, 1, 0, 0, 2, 3, 0);
        vecs[13] = mk(0, 1, 0, 1, 0, 0, 2, 3, 0);  // fall in SET ignored
        vecs[14] = mk(0, 1, 0, 0, 0, 1, 3, 3, 0);  // current state SET applies
        vecs[15] = mk(0, 1, 0, 0, 0, 1, 3, 3, 0);  // RUN ignores inc_hour
        vecs[16] = mk(0, 0, 0, 0, 1, 0, 3, 3, 0);  // RUN ignores inc_min
        vecs[17] = mk(0, 0, 0, 1, 1, 1, 3, 3, 0);  // STOP ignores incs
        vecs[18] = mk(0, 0, 1, 0, 0, 0, 3, 3, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 3, 3, 0);  // STOP ignores fall

        for (int i = 0; i < 20; i++) begin
            cyc(vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].sm, vecs[i].im, vecs[i].ih);
            expect_time($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, int'(vecs[i].ed));
            check($sformatf("vec%0d_min_tic", i), int'(min_tic), 0);
        end
        check("vec_final_state", int'(dut.state), int'(STOP));

        // Midnight rollover from 23:59 with a one-cycle day_tic.
        set_time(23, 59);
        expect_time("preload_2359", 23, 59, 0);
        check("preload_min_tic", int'(min_tic), 1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        expect_time("roll_before", 23, 59, 0);
        cyc(0, 1, 0, 0, 0, 0);
        expect_time("roll_edge", 0, 0, 1);
        check("roll_min_tic", int'(min_tic), 0);
        cyc(0, 1, 0, 0, 0, 0);
        expect_time("roll_after", 0, 0, 0);

        // Manual wrap past midnight in SET never raises day_tic.
        set_time(23, 59);
        cyc(0, 1, 0, 1, 1, 1);
        expect_time("set_wrap", 0, 0, 0);

        // inc_min at 59 in SET wraps without carrying into hour.
        set_time(4, 59);
        cyc(0, 1, 0, 1, 1, 0);
        expect_time("set_min_wrap", 4, 0, 0);

        // en drop together with sec_tic: no increment, STOP, resume on en.
        set_time(10, 20);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        expect_time("en_drop", 10, 20, 0);
        check("en_drop_state", int'(dut.state), int'(STOP));
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        expect_time("en_low_hold", 10, 20, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("en_restore_state", int'(dut.state), int'(RUN));
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        expect_time("en_resume", 10, 21, 0);

        // Both increments at 05:59 in SET; a sec_tic fall in SET is ignored.
        set_time(5, 59);
        cyc(0, 1, 0, 1, 1, 1);
        expect_time("set_both", 6, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        expect_time("set_fall", 6, 0, 0);

        // Reset in the cycle of a minute event discards it, no stale event.
        set_time(12, 34);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        expect_time("rst_event", 0, 0, 0);
        check("rst_event_state", int'(dut.state), int'(STOP));
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        expect_time("rst_no_stale", 0, 0, 0);

        // 12-hour instance: eleven inc_hour pulses then one more.
        @(posedge clk); #1;
        reset_b = 1'b0; en_b = 1'b1; set_mode_b = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            inc_hour_b = 1'b1;
            @(posedge clk); #1;
            inc_hour_b = 1'b0;
            @(posedge clk); #1;
        end
        check("h12_eleven", int'(hour_b), 11);
        inc_hour_b = 1'b1;
        @(posedge clk); #1;
        inc_hour_b = 1'b0;
        check("h12_wrap", int'(hour_b), 0);
        check("h12_day", int'(day_tic_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/min_hour_gen.md
MIN_HOUR_GEN -- requirements
Module: min_hour_gen

Interface
REQ-001 Parameter P_MIN_BIT, default 6, minute output width.
REQ-002 Parameter P_HOUR_BIT, default 5, hour output width.
REQ-003 Parameter P_HOUR_MAX, default 24, hour modulus; the minute modulus is fixed at 60.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset_all  input  1  synchronous, active-high reset.
REQ-006 en  input  1  run enable, shared with the upstream seconds stage.
REQ-007 sec_tic  input  1  upstream level, high for the whole second in which sec==59.
REQ-008 set_mode  input  1  level; 1 = time-setting mode.
REQ-009 inc_min  input  1  single-cycle debounced pulse; minute +1 in set mode.
REQ-010 inc_hour  input  1  single-cycle debounced pulse; hour +1 in set mode.
REQ-011 min  output  P_MIN_BIT  registered minute count, 0..59.
REQ-012 hour  output  P_HOUR_BIT  registered hour count, 0..P_HOUR_MAX-1.
REQ-013 min_tic  output  1  combinational level, high while min==59.
REQ-014 day_tic  output  1  registered one-cycle pulse on rollover from (P_HOUR_MAX-1):59 to 00:00.

Function
REQ-015 The block SHALL register sec_tic into sec_tic_d and register en into en_d every cycle, in all states.
REQ-016 A minute event SHALL be sec_tic_d=1 AND sec_tic=0 AND en=1 AND en_d=1. This rule keeps the upstream clear on en falling from counting as a minute.
REQ-017 The FSM states SHALL be STOP, RUN and SET, each held in a state register.
REQ-018 Any state SHALL go to STOP when en=0.
REQ-019 When en=1, any state SHALL go to SET when set_mode=1 and to RUN when set_mode=0.
REQ-020 Behaviour in a cycle SHALL be decided by the current (registered) state, not by the next state.
REQ-021 STOP: min and hour SHALL hold their values; minute events, inc_min and inc_hour SHALL be ignored.
REQ-022 RUN: on a minute event, min SHALL increment; 59 wraps to 0 and carries +1 into hour.
REQ-023 RUN: the hour SHALL wrap from P_HOUR_MAX-1 to 0.
REQ-024 RUN: inc_min and inc_hour SHALL be ignored.
REQ-025 RUN latency: if sec_tic falls between cycles k and k+1, the new min SHALL be visible in cycle k+2.
REQ-026 SET: inc_min SHALL do min+1 with a 59 to 0 wrap and no hour carry.
REQ-027 SET: inc_hour SHALL do hour+1 with a wrap from P_HOUR_MAX-1 to 0.
REQ-028 SET: minute events SHALL be ignored, and day_tic SHALL never assert.
REQ-029 SET: when inc_min and inc_hour are high in the same cycle, both SHALL apply.
REQ-030 day_tic SHALL be high only in the cycle in which min and hour first show 0 after a RUN rollover.
REQ-031 All arithmetic SHALL be modulo; min never exceeds 59 and hour never exceeds P_HOUR_MAX-1.

Reset
REQ-032 reset_all SHALL take priority over every other input.
REQ-033 On reset_all=1, in the next cycle min=0, hour=0, day_tic=0, sec_tic_d=0, en_d=0 and state=STOP.
REQ-034 A reset asserted in the same cycle as a minute event or an inc pulse SHALL discard that event.

Structure
REQ-035 The shared package clock_pkg SHALL hold the STOP/RUN/SET state encoding and the constants C_MIN_MAX=60 and C_HOUR_MAX_DEF=24; the seconds stage also uses C_MIN_MAX.
REQ-036 The sub-module mod_counter SHALL be a modulus-N wrap counter with inputs inc and clr and outputs cnt and wrap.
REQ-037 mod_counter SHALL be instantiated twice, once for minutes and once for hours; the FSM and edge detection live in min_hour_gen.

Verification
REQ-038 Reset, then en=1, set_mode=0, sec_tic high for 5 cycles then low -> min=1 exactly 2 cycles after the fall; hour=0; day_tic=0.
REQ-039 Preload 23:59 through SET, return to RUN, apply one sec_tic fall -> min=0 and hour=0 in the same cycle, day_tic high for exactly 1 cycle.
REQ-040 RUN at 10:20 with sec_tic=1, drop en and sec_tic together -> no increment; state=STOP; 10:20 held; en=1 restores RUN.
REQ-041 SET at 05:59, inc_min and inc_hour pulsed in the same cycle -> 06:00 with no double hour carry; a sec_tic fall during SET leaves time unchanged.
REQ-042 RUN at 12:34, reset_all asserted in the cycle of a minute event -> 00:00, STOP, day_tic=0; no increment afterwards from the stale sec_tic_d.
REQ-043 P_HOUR_MAX=12, 11 inc_hour pulses from 0 then one more -> hour=11 then hour=0.
